// File: rtl/sevenseg_scan_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sevenseg_scan_ctl                                          |
// | Desc    : Multiplexed seven-segment scan controller with guard gap,  |
// |           shadow display registers and leading-zero suppression.    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sevenseg_scan_ctl #(
  parameter int NDIG  = 8,
  parameter int DIV   = 100000,
  parameter int GUARD = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] val,
  input  logic [NDIG-1:0]   dp_mask,
  input  logic [NDIG-1:0]   dash_mask,
  input  logic [NDIG-1:0]   blank_mask,
  input  logic              lz_en,
  output logic [6:0]        d_out,
  output logic [NDIG-1:0]   an_n,
  output logic [2:0]        digit_idx,
  output logic              frame_done
);

  localparam int            CW           = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] c_CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] c_GUARD_LAST = CW'((GUARD > 0) ? (GUARD - 1) : 0);
  localparam logic [2:0]    c_IDX_LAST   = 3'(NDIG - 1);
  localparam logic [6:0]    c_BLANK      = 7'b1000000;

  typedef enum logic [0:0] {
    S_GUARD = 1'b0,
    S_ON    = 1'b1
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_idx;
  logic [6:0]        r_d_out;
  logic [NDIG-1:0]   r_an_n;
  logic              r_frame_done;

  logic [4*NDIG-1:0] r_val;
  logic [NDIG-1:0]   r_dp;
  logic [NDIG-1:0]   r_dash;
  logic [NDIG-1:0]   r_blank;
  logic              r_lz;

  state_t            w_state_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_wrap;
  logic [2:0]        w_idx_inc;
  logic [2:0]        w_idx_new;
  logic [NDIG-1:0]   w_an_nxt;
  logic [31:0]       w_val8;
  logic [7:0]        w_dp8;
  logic [7:0]        w_dash8;
  logic [7:0]        w_blank8;
  logic [7:0]        w_sup;
  logic              w_run;
  logic [6:0]        w_code_nxt;

  // Shadow registers: written any time, sampled only at a slot start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val   <= '0;
      r_dp    <= '0;
      r_dash  <= '0;
      r_blank <= '0;
      r_lz    <= 1'b0;
    end else if (load) begin
      r_val   <= val;
      r_dp    <= dp_mask;
      r_dash  <= dash_mask;
      r_blank <= blank_mask;
      r_lz    <= lz_en;
    end
  end

  // Zero-extend to eight digits so the digit index selects without range issues.
  assign w_val8   = 32'(r_val);
  assign w_dp8    = 8'(r_dp);
  assign w_dash8  = 8'(r_dash);
  assign w_blank8 = 8'(r_blank);

  always_comb begin
    w_run = r_lz;
    w_sup = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_run    = w_run & (w_val8[4*i +: 4] == 4'h0) & ~w_dp8[i] & ~w_dash8[i];
      w_sup[i] = w_run & (i != 0);
    end
  end

  assign w_idx_inc  = (r_idx == c_IDX_LAST) ? 3'd0 : (r_idx + 3'd1);
  assign w_idx_new  = w_wrap ? w_idx_inc : r_idx;
  assign w_code_nxt = {w_blank8[w_idx_new] | w_sup[w_idx_new],
                       w_dp8[w_idx_new],
                       w_dash8[w_idx_new],
                       w_val8[{w_idx_new, 2'b00} +: 4]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wrap      = 1'b0;
    if (en) begin
      if (r_cnt == c_CNT_LAST) begin
        w_cnt_nxt   = '0;
        w_wrap      = 1'b1;
        w_state_nxt = (GUARD == 0) ? S_ON : S_GUARD;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
        if ((r_state == S_GUARD) && ((GUARD == 0) || (r_cnt == c_GUARD_LAST))) begin
          w_state_nxt = S_ON;
        end
      end
    end
    w_an_nxt = (en && (w_state_nxt == S_ON)) ? ~(NDIG'(1) << w_idx_new) : '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_GUARD;
      r_cnt        <= '0;
      r_idx        <= 3'd0;
      r_d_out      <= c_BLANK;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_new;
      r_an_n       <= w_an_nxt;
      r_frame_done <= w_wrap && (r_idx == c_IDX_LAST);
      if (w_wrap) begin
        r_d_out <= w_code_nxt;
      end
    end
  end

  assign d_out      = r_d_out;
  assign an_n       = r_an_n;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_sevenseg_scan_ctl                                       |
// | Desc    : Self-checking bench for sevenseg_scan_ctl (4 digits).      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_sevenseg_scan_ctl;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] val;
  logic [3:0]  dp_mask;
  logic [3:0]  dash_mask;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [6:0]  d_out,      d_out_g0;
  logic [3:0]  an_n,       an_n_g0;
  logic [2:0]  digit_idx,  digit_idx_g0;
  logic        frame_done, frame_done_g0;

  int         n_vec = 0;
  int         n_err = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  sevenseg_scan_ctl #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .val(val),
    .dp_mask(dp_mask), .dash_mask(dash_mask), .blank_mask(blank_mask), .lz_en(lz_en),
    .d_out(d_out), .an_n(an_n), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  sevenseg_scan_ctl #(.NDIG(NDIG), .DIV(DIV), .GUARD(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .val(val),
    .dp_mask(dp_mask), .dash_mask(dash_mask), .blank_mask(blank_mask), .lz_en(lz_en),
    .d_out(d_out_g0), .an_n(an_n_g0), .digit_idx(digit_idx_g0), .frame_done(frame_done_g0)
  );

  // Expected code: suppression covers every digit above the most significant
  // "visible" digit (non-zero nibble, dp or dash), never digit 0.
  function automatic logic [6:0] model_code(input logic [15:0] v, input logic [3:0] dp,
                                            input logic [3:0] dash, input logic [3:0] blank,
                                            input logic lz, input int i);
    int   top;
    logic sup;
    top = -1;
    for (int j = 0; j < NDIG; j++)
      if ((v[4*j +: 4] != 4'h0) || dp[j] || dash[j]) top = j;
    sup = lz && (i != 0) && (i > top);
    return {blank[i] | sup, dp[i], dash[i], v[4*i +: 4]};
  endfunction

  // Drive a load strobe and queue the codes the next frame should show.
  task automatic apply(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] dash,
                       input logic [3:0] blank, input logic lz);
    val = v; dp_mask = dp; dash_mask = dash; blank_mask = blank; lz_en = lz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < NDIG; i++) exp_q.push_back(model_code(v, dp, dash, blank, lz, i));
  endtask

  task automatic wait_frame(input bit g0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((g0 ? frame_done_g0 : frame_done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (an_n !== 4'b1111 || d_out !== 7'b1000000 || digit_idx !== 3'd0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: an_n=%b d_out=%h idx=%0d fd=%b, want 1111 40 0 0", an_n, d_out, digit_idx, frame_done);
    end
  endtask

  task automatic test_scan_order();
    bit ok; logic [6:0] ec; logic [3:0] ea;
    apply(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_frame(1'b0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL scan_sync: frame_done=0 after 100 cycles, want 1"); end
    for (int s = 0; s < NDIG; s++) begin
      ec = exp_q.pop_front();
      for (int c = 0; c < DIV; c++) begin
        ea = (c < GUARD) ? 4'b1111 : ~(4'b0001 << s);
        n_vec++;
        if (an_n !== ea || d_out !== ec || digit_idx !== 3'(s) || frame_done !== (s == 0 && c == 0)) begin
          n_err++;
          $display("FAIL scan slot %0d cyc %0d: an_n=%b d_out=%h idx=%0d fd=%b, want %b %h %0d %b",
                   s, c, an_n, d_out, digit_idx, frame_done, ea, ec, s, (s == 0 && c == 0));
        end
        @(negedge clk);
      end
    end
    n_vec++;
    if (frame_done !== 1'b1) begin n_err++; $display("FAIL frame_period: fd=%b after 32 cycles, want 1", frame_done); end
  endtask

  task automatic test_leading_zeros();
    bit ok; logic [6:0] ec; logic [3:0] ea;
    logic [15:0] vals [2];
    vals = '{16'h0050, 16'h0000};
    for (int t = 0; t < 2; t++) begin
      apply(vals[t], 4'b0000, 4'b0000, 4'b0000, 1'b1);
      wait_frame(1'b0, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL lz_sync: frame_done=0 after 100 cycles, want 1"); end
      for (int s = 0; s < NDIG; s++) begin
        ec = exp_q.pop_front();
        for (int c = 0; c < DIV; c++) begin
          ea = (c < GUARD) ? 4'b1111 : ~(4'b0001 << s);
          n_vec++;
          if (an_n !== ea || d_out !== ec) begin
            n_err++;
            $display("FAIL lz val=%h slot %0d cyc %0d: an_n=%b d_out=%h, want %b %h", vals[t], s, c, an_n, d_out, ea, ec);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_supp_stop();
    bit ok; logic [6:0] ec;
    apply(16'h0007, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    wait_frame(1'b0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL supp_sync: frame_done=0 after 100 cycles, want 1"); end
    for (int s = 0; s < NDIG; s++) begin
      ec = exp_q.pop_front();
      for (int c = 0; c < DIV; c++) begin
        n_vec++;
        if (d_out !== ec || digit_idx !== 3'(s)) begin
          n_err++;
          $display("FAIL supp_stop slot %0d cyc %0d: d_out=%h idx=%0d, want %h %0d", s, c, d_out, digit_idx, ec, s);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_dash_blank();
    bit ok; logic [6:0] ec;
    logic [3:0] dashes [2];
    dashes = '{4'b1000, 4'b1001};
    for (int t = 0; t < 2; t++) begin
      apply(16'h1234, 4'b0000, dashes[t], 4'b0001, 1'b0);
      wait_frame(1'b0, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL dash_sync: frame_done=0 after 100 cycles, want 1"); end
      for (int s = 0; s < NDIG; s++) begin
        ec = exp_q.pop_front();
        for (int c = 0; c < DIV; c++) begin
          n_vec++;
          if (d_out !== ec) begin
            n_err++;
            $display("FAIL dash_blank dash=%b slot %0d cyc %0d: d_out=%h, want %h", dashes[t], s, c, d_out, ec);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_load_timing();
    bit ok; logic [6:0] old1, new2;
    apply(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_frame(1'b0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL load_sync: frame_done=0 after 100 cycles, want 1"); end
    void'(exp_q.pop_front());
    old1 = exp_q.pop_front();
    exp_q.delete();
    new2 = model_code(16'h9ABC, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2);
    repeat (DIV + GUARD + 3) @(negedge clk);
    val = 16'hFEDC; load = 1'b1;
    @(negedge clk);
    val = 16'h9ABC;
    for (int c = 0; c < 2; c++) begin
      n_vec++;
      if (d_out !== old1 || an_n !== 4'b1101) begin
        n_err++;
        $display("FAIL load_hold cyc %0d: d_out=%h an_n=%b, want %h 1101", c, d_out, an_n, old1);
      end
      @(negedge clk);
      load = 1'b0;
    end
    n_vec++;
    if (d_out !== new2 || digit_idx !== 3'd2) begin
      n_err++;
      $display("FAIL load_apply: d_out=%h idx=%0d, want %h 2", d_out, digit_idx, new2);
    end
  endtask

  task automatic test_enable();
    bit ok;
    apply(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_frame(1'b0, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL en_sync: frame_done=0 after 100 cycles, want 1"); end
    exp_q.delete();
    repeat (DIV + 4) @(negedge clk);
    n_vec++;
    if (an_n !== 4'b1101) begin n_err++; $display("FAIL en_pre: an_n=%b, want 1101", an_n); end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (an_n !== 4'b1111 || digit_idx !== 3'd1 || d_out !== 7'h03) begin
        n_err++;
        $display("FAIL en_freeze %0d: an_n=%b idx=%0d d_out=%h, want 1111 1 03", k, an_n, digit_idx, d_out);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (an_n !== 4'b1101 || digit_idx !== 3'd1) begin
        n_err++;
        $display("FAIL en_resume %0d: an_n=%b idx=%0d, want 1101 1", k, an_n, digit_idx);
      end
    end
    @(negedge clk);
    n_vec++;
    if (an_n !== 4'b1111 || digit_idx !== 3'd2 || d_out !== 7'h02) begin
      n_err++;
      $display("FAIL en_next_slot: an_n=%b idx=%0d d_out=%h, want 1111 2 02", an_n, digit_idx, d_out);
    end
  endtask

  task automatic test_reset_async();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (an_n !== 4'b1111 || d_out !== 7'b1000000 || digit_idx !== 3'd0 || frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: an_n=%b d_out=%h idx=%0d fd=%b, want 1111 40 0 0", an_n, d_out, digit_idx, frame_done);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (an_n !== 4'b1111 || digit_idx !== 3'd0) begin
      n_err++;
      $display("FAIL rst_guard: an_n=%b idx=%0d, want 1111 0", an_n, digit_idx);
    end
    @(negedge clk);
    n_vec++;
    if (an_n !== 4'b1110 || digit_idx !== 3'd0) begin
      n_err++;
      $display("FAIL rst_first_on: an_n=%b idx=%0d, want 1110 0", an_n, digit_idx);
    end
  endtask

  task automatic test_guard0();
    bit ok; logic [6:0] ec; logic [3:0] ea;
    apply(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    wait_frame(1'b1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL g0_sync: frame_done=0 after 100 cycles, want 1"); end
    for (int s = 0; s < NDIG; s++) begin
      ec = exp_q.pop_front();
      for (int c = 0; c < DIV; c++) begin
        ea = ~(4'b0001 << s);
        n_vec++;
        if (an_n_g0 !== ea || d_out_g0 !== ec || digit_idx_g0 !== 3'(s)) begin
          n_err++;
          $display("FAIL guard0 slot %0d cyc %0d: an_n=%b d_out=%h idx=%0d, want %b %h %0d",
                   s, c, an_n_g0, d_out_g0, digit_idx_g0, ea, ec, s);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; val = '0;
    dp_mask = '0; dash_mask = '0; blank_mask = '0; lz_en = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    en  = 1'b1;
    test_scan_order();
    test_leading_zeros();
    test_supp_stop();
    test_dash_blank();
    test_load_timing();
    test_enable();
    test_reset_async();
    test_guard0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
